bit_serial_alu_seq: RTL and testbench
=====================================

BIT_SERIAL_ALU_SEQ -- requirements
Module: bit_serial_alu_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; all counts below assume 16.
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  request; sampled only in IDLE.
REQ-005 OP  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110/111 illegal.
REQ-006 OPA / OPB  input  16 each  operands, captured on accepted START.
REQ-007 BUSY  output  1  high from the cycle after an accepted START until the DONE cycle, inclusive.
REQ-008 DONE  output  1  one-cycle pulse, result valid.
REQ-009 RESULT  output  16  result, held from DONE until the next accepted START.
REQ-010 CARRY / OVF / ERR  output  1 each  final carry-out, signed overflow, illegal-op flag; held like RESULT.
REQ-011 S_A, S_B, S_CIN, S_BINVERT, S_LESS  output  1 each  drive to the external 1-bit ALU slice.
REQ-012 S_ALUCTRL  output  3  slice select: 0 AND, 1 OR, 2 ADD, 3 XOR, 5 LESS.
REQ-013 S_REZ / S_COUT  input  1 each  combinational slice result and carry-out.

Function
REQ-014 FSM states SHALL be IDLE, RUN, SLT2, FIN.
- IDLE->RUN on START with legal OP.
- IDLE->FIN on START with illegal OP.
- RUN->FIN after bit 15, or RUN->SLT2 when OP=SLT.
- SLT2->FIN after bit 15.
- FIN->IDLE unconditionally.
REQ-015 On an accepted START, OPA, OPB and OP SHALL be latched into shift registers, bit index cleared to 0, carry register loaded with 1 for SUB/SLT and 0 otherwise.
REQ-016 Each RUN/SLT2 cycle SHALL present bit i of each operand on S_A/S_B (LSB first), the carry register on S_CIN, sample S_REZ into RESULT bit i, load S_COUT into the carry register, and increment i.
REQ-017 RUN slice drive SHALL be:
- S_BINVERT=1 for SUB/SLT, else 0.
- S_ALUCTRL=2 for ADD/SUB/SLT, 0/1/3 for AND/OR/XOR.
- S_LESS=0.
REQ-018 In RUN, at i=15 the block SHALL capture S_CIN and S_COUT; OVF = S_CIN xor S_COUT for ADD/SUB/SLT; CARRY = S_COUT for ADD/SUB.
REQ-019 SLT: set = REZ15 xor OVF from the RUN pass. SLT2 SHALL drive S_ALUCTRL=5, S_BINVERT=0, S_CIN=0, and S_LESS=set at i=0 (0 otherwise), so RESULT = {15'b0, set}. CARRY=0 and OVF=0 are reported.
REQ-020 For AND/OR/XOR, CARRY and OVF SHALL be 0.
REQ-021 In FIN, DONE SHALL be 1 for exactly one cycle, with RESULT/CARRY/OVF/ERR stable.
REQ-022 Latency from START cycle to DONE: 17 cycles for logic/ADD/SUB, 33 for SLT, 1 for illegal OP.
REQ-023 Illegal OP: RESULT=0, CARRY=0, OVF=0, ERR=1, no slice activity.
REQ-024 Legal OP: ERR=0.
REQ-025 START while not in IDLE (including the FIN cycle) SHALL be ignored, with no effect on the operation in flight.
REQ-026 Outside RUN/SLT2, all S_* outputs SHALL be 0.
REQ-027 Arithmetic is modulo 2^16; wrap-around is reflected only in CARRY/OVF.
REQ-028 The block SHALL NOT use S_ALUCTRL value 4.

Reset
REQ-029 RST_N low SHALL immediately force IDLE, BUSY=0, DONE=0, RESULT=0, CARRY=0, OVF=0, ERR=0, all S_*=0, bit index 0, carry register 0.
REQ-030 Reset mid-operation SHALL abort without a DONE pulse; the first START after release is accepted normally.

Verification (bench supplies a behavioural 1-bit slice)
REQ-031 ADD 0xFFFF+0x0001 -> DONE at cycle 17, RESULT=0x0000, CARRY=1, OVF=0.
REQ-032 SUB 0x8000-0x0001 -> RESULT=0x7FFF, CARRY=1, OVF=1; AND 0xF0F0,0x3C3C -> RESULT=0x3030, CARRY=0.
REQ-033 SLT 0x8000 vs 0x0001 -> DONE at cycle 33, RESULT=0x0001. SLT 0x0005 vs 0x0005 -> RESULT=0x0000.
REQ-034 OP=111 -> DONE at cycle 1, ERR=1, RESULT=0, S_* stay 0. A following legal ADD clears ERR.
REQ-035 Back-to-back: second START pulsed at cycle 5 and at the FIN cycle is ignored; a START one cycle after DONE is accepted and BUSY is continuous only per operation.
REQ-036 RST_N pulsed low at cycle 9 of an XOR -> outputs zero asynchronously, no DONE; a new OR 0x00FF|0x0F00 then yields 0x0FFF.

Source files
------------

// File: rtl/bit_serial_alu_seq_if.sv
// Request/response bundle for bit_serial_alu_seq.
//   start, op, opa, opb        : request, driven by the master
//   busy, done, result, carry,
//   ovf, err                   : status and result, driven by the ALU (slave)
interface bit_serial_alu_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result, carry, ovf, err
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result, carry, ovf, err
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer driving an external 1-bit ALU slice, LSB first.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   bus                 : request/result bundle (slave side)
//   s_a, s_b, s_cin,
//   s_binvert, s_less,
//   s_aluctrl           : drive to the slice (all zero outside RUN/SLT2)
//   s_rez, s_cout       : combinational slice result and carry-out
// SLT takes two passes: a subtract pass to find the sign, then a LESS pass
// that writes the comparison bit into result bit 0.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_serial_alu_seq_if.slave  bus,
  output logic                 s_a,
  output logic                 s_b,
  output logic                 s_cin,
  output logic                 s_binvert,
  output logic                 s_less,
  output logic [2:0]           s_aluctrl,
  input  logic                 s_rez,
  input  logic                 s_cout
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;

  localparam logic [2:0] CtrlAnd  = 3'd0;
  localparam logic [2:0] CtrlOr   = 3'd1;
  localparam logic [2:0] CtrlAdd  = 3'd2;
  localparam logic [2:0] CtrlXor  = 3'd3;
  localparam logic [2:0] CtrlLess = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StSlt2, StFin} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IdxW-1:0]  idx_q;
  logic             cin_q;
  logic             set_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;

  logic op_legal;
  logic op_negb;
  logic op_addsub;
  logic run_ovf;

  assign op_legal  = (bus.op <= OpSlt);
  assign op_negb   = (op_q == OpSub) || (op_q == OpSlt);
  assign op_addsub = (op_q == OpAdd) || (op_q == OpSub);
  // Overflow of the MSB stage: carry into bit 15 differs from carry out.
  assign run_ovf   = cin_q ^ s_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      set_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q     <= bus.op;
            a_q      <= bus.opa;
            b_q      <= bus.opb;
            idx_q    <= '0;
            set_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (op_legal) begin
              state_q <= StRun;
              err_q   <= 1'b0;
              cin_q   <= (bus.op == OpSub) || (bus.op == OpSlt);
            end else begin
              state_q <= StFin;
              err_q   <= 1'b1;
              cin_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StRun, StSlt2: begin
          result_q[idx_q] <= s_rez;
          cin_q           <= s_cout;
          idx_q           <= idx_q + 1'b1;
          // Rotate so the operands are intact again for the SLT second pass.
          a_q             <= {a_q[0], a_q[WIDTH-1:1]};
          b_q             <= {b_q[0], b_q[WIDTH-1:1]};
          if (idx_q == LastIdx) begin
            if (state_q == StRun && op_q == OpSlt) begin
              set_q   <= s_rez ^ run_ovf;
              state_q <= StSlt2;
            end else begin
              if (state_q == StRun && op_addsub) begin
                carry_q <= s_cout;
                ovf_q   <= run_ovf;
              end
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    s_a       = 1'b0;
    s_b       = 1'b0;
    s_cin     = 1'b0;
    s_binvert = 1'b0;
    s_less    = 1'b0;
    s_aluctrl = CtrlAnd;
    unique case (state_q)
      StRun: begin
        s_a       = a_q[0];
        s_b       = b_q[0];
        s_cin     = cin_q;
        s_binvert = op_negb;
        case (op_q)
          OpAnd:   s_aluctrl = CtrlAnd;
          OpOr:    s_aluctrl = CtrlOr;
          OpXor:   s_aluctrl = CtrlXor;
          default: s_aluctrl = CtrlAdd;
        endcase
      end
      StSlt2: begin
        s_a       = a_q[0];
        s_b       = b_q[0];
        s_aluctrl = CtrlLess;
        s_less    = set_q && (idx_q == '0);
      end
      default: ;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq with a behavioural 1-bit slice
// and a word-level reference model feeding a scoreboard queue.
module tb_bit_serial_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_a, s_b, s_cin, s_binvert, s_less;
  logic [2:0] s_aluctrl;
  logic       s_rez, s_cout;

  bit_serial_alu_seq_if #(.WIDTH(16)) bus ();

  bit_serial_alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_cin     (s_cin),
    .s_binvert (s_binvert),
    .s_less    (s_less),
    .s_aluctrl (s_aluctrl),
    .s_rez     (s_rez),
    .s_cout    (s_cout)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice.
  logic bb;
  always_comb begin
    bb     = s_b ^ s_binvert;
    s_cout = (s_a & bb) | (s_a & s_cin) | (bb & s_cin);
    case (s_aluctrl)
      3'd0:    s_rez = s_a & bb;
      3'd1:    s_rez = s_a | bb;
      3'd2:    s_rez = s_a ^ bb ^ s_cin;
      3'd3:    s_rez = s_a ^ bb;
      3'd5:    s_rez = s_less;
      default: s_rez = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        ovf;
    logic        err;
    logic [31:0] lat;
    logic [31:0] start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    e = '0;
    e.lat = 17;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b100: e.result = a ^ b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        e.result = s[15:0];
        e.carry  = s[16];
        e.ovf    = (a[15] == b[15]) && (s[15] != a[15]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        e.result = s[15:0];
        e.carry  = s[16];
        e.ovf    = (a[15] != b[15]) && (s[15] != a[15]);
      end
      3'b101: begin
        e.result = {15'b0, ($signed(a) < $signed(b))};
        e.lat    = 33;
      end
      default: begin
        e.err = 1'b1;
        e.lat = 1;
      end
    endcase
    return e;
  endfunction

  // Monitor: pop and compare on every DONE.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      check_eq("slice_idle_at_done", {29'b0, s_aluctrl, s_a, s_b, s_cin, s_binvert, s_less}, 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_exp = e;
        check_eq("result", {16'b0, bus.result}, {16'b0, e.result});
        check_eq("carry", bus.carry, e.carry);
        check_eq("ovf", bus.ovf, e.ovf);
        check_eq("err", bus.err, e.err);
        check_eq("latency", cyc - e.start_cyc, e.lat);
        check_eq("busy_at_done", bus.busy, 1);
      end
    end
    if (rst_n && bus.busy && s_aluctrl == 3'd4) check_eq("aluctrl4", 1, 0);
  end

  // Drive one START for one cycle and push its expected outcome.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    e = model(op, a, b);
    e.start_cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 0, 1);
      sb.delete();
    end
    #1;
  endtask

  task automatic run(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    issue(op, a, b);
    wait_done(60);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold", {13'b0, bus.result, bus.carry, bus.ovf, bus.err},
             {13'b0, last_exp.result, last_exp.carry, last_exp.ovf, last_exp.err});
    check_eq("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int n0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.opa   = '0;
    bus.opb   = '0;
    #12;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_out", {12'b0, bus.result, bus.carry, bus.ovf, bus.err}, 0);
    check_eq("rst_slice", {29'b0, s_aluctrl, s_a, s_b, s_cin, s_binvert, s_less}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(3'b010, 16'hFFFF, 16'h0001);
    run(3'b011, 16'h8000, 16'h0001);
    run(3'b000, 16'hF0F0, 16'h3C3C);
    run(3'b101, 16'h8000, 16'h0001);
    run(3'b101, 16'h0005, 16'h0005);
    run(3'b101, 16'h0003, 16'hFFFE);
    run(3'b100, 16'hA5A5, 16'h0FF0);
    run(3'b001, 16'h1200, 16'h0034);
    run(3'b010, 16'h7FFF, 16'h0001);

    // Illegal op: immediate DONE, no slice activity in between.
    issue(3'b111, 16'h1234, 16'h5678);
    check_eq("illegal_slice", {29'b0, s_aluctrl, s_a, s_b, s_cin, s_binvert, s_less}, 0);
    wait_done(10);
    run(3'b010, 16'h0001, 16'h0002);
    run(3'b110, 16'hFFFF, 16'hFFFF);

    // Back-to-back: STARTs mid-op and in the FIN cycle are ignored.
    issue(3'b010, 16'h1111, 16'h2222);
    n0 = cyc - 1;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 3'b011; bus.opa = 16'hDEAD; bus.opb = 16'hBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < n0 + 17) begin @(posedge clk); #1; end
    check_eq("fin_done", bus.done, 1);
    bus.start = 1'b1; bus.op = 3'b111;
    @(posedge clk); #1;
    check_eq("gap_busy", bus.busy, 0);
    check_eq("fin_start_ignored_err", bus.err, 0);
    bus.op = 3'b001; bus.opa = 16'h00F0; bus.opb = 16'h0F00;
    begin
      exp_t e;
      e = model(3'b001, 16'h00F0, 16'h0F00);
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("next_busy", bus.busy, 1);
    wait_done(40);

    // Asynchronous reset in the middle of an XOR.
    issue(3'b100, 16'hFFFF, 16'h1234);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_out", {12'b0, bus.result, bus.carry, bus.ovf, bus.err}, 0);
    check_eq("arst_slice", {29'b0, s_aluctrl, s_a, s_b, s_cin, s_binvert, s_less}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check_eq("arst_no_done", bus.busy, 0);
    run(3'b001, 16'h00FF, 16'h0F00);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 5));
      run(op, 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "global timeout");
  end

endmodule
